// File: rtl/snn_spi_master.sv
// SPI mode-0 master for the SNN core's slave port: one instruction/address/data
// frame per host request, 32-bit MISO capture on reads, then chip-select-high flush pulses.
module snn_spi_master #(
    parameter int                           INSTR_TRANS_WIDTH = 7,
    parameter int                           ADDR_TRANS_WIDTH  = 16,
    parameter int                           DATA_WIDTH        = 32,
    parameter int                           ADDR_WIDTH        = 9,
    parameter logic [INSTR_TRANS_WIDTH-1:0] INSTR_WRITE       = 7'b0000010,
    parameter logic [INSTR_TRANS_WIDTH-1:0] INSTR_READ        = 7'b0000011,
    parameter int                           CLK_DIV           = 2,
    parameter int                           GAP_PULSES        = 2
) (
    input  logic                  clk_snn,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  clk_spi_o,
    output logic                  cs_n_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    localparam int FRAME_SLOTS = INSTR_TRANS_WIDTH + ADDR_TRANS_WIDTH + DATA_WIDTH + 2;
    localparam int DATA_FIRST  = 1 + INSTR_TRANS_WIDTH + ADDR_TRANS_WIDTH;
    localparam int CNT_MAX     = (FRAME_SLOTS > GAP_PULSES) ? FRAME_SLOTS : GAP_PULSES;
    localparam int SW          = $clog2(CNT_MAX + 1);
    localparam int DIVW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);
    localparam logic [SW-1:0]   LAST_SLOT = SW'(FRAME_SLOTS - 1);
    localparam logic [SW-1:0]   SAMPLE_LO = SW'(DATA_FIRST - 1);
    localparam logic [SW-1:0]   SAMPLE_HI = SW'(DATA_FIRST + DATA_WIDTH - 2);
    localparam logic [SW-1:0]   GAP_LAST  = SW'((GAP_PULSES > 0) ? GAP_PULSES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                 state;
    logic [DIVW-1:0]        div_cnt;
    logic [SW-1:0]          slot_cnt;
    logic [FRAME_SLOTS-1:0] frame_sr;
    logic [DATA_WIDTH-1:0]  rd_shift;
    logic                   is_read;
    logic                   div_tick;

    assign div_tick = (div_cnt == DIV_LAST);

    // clk_spi_o doubles as the half-period phase; slot_cnt counts frame slots in
    // SHIFT and flush pulses in GAP. MISO is sampled on the cycle SCLK is driven high.
    always_ff @(posedge clk_snn) begin
        if (rst_i) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            slot_cnt  <= '0;
            frame_sr  <= '0;
            rd_shift  <= '0;
            is_read   <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rdata_o   <= '0;
            clk_spi_o <= 1'b0;
            cs_n_o    <= 1'b1;
            mosi_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        state     <= S_SETUP;
                        busy_o    <= 1'b1;
                        cs_n_o    <= 1'b0;
                        clk_spi_o <= 1'b0;
                        mosi_o    <= 1'b0;
                        div_cnt   <= '0;
                        slot_cnt  <= '0;
                        is_read   <= ~we_i;
                        rd_shift  <= '0;
                        frame_sr  <= {1'b0,
                                      we_i ? INSTR_WRITE : INSTR_READ,
                                      ADDR_TRANS_WIDTH'(addr_i),
                                      wdata_i & {DATA_WIDTH{we_i}},
                                      1'b0};
                    end
                end
                S_SETUP: begin
                    if (div_tick) begin
                        div_cnt   <= '0;
                        state     <= S_SHIFT;
                        clk_spi_o <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!div_tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (clk_spi_o) begin
                            clk_spi_o <= 1'b0;
                            if (slot_cnt != LAST_SLOT) begin
                                mosi_o   <= frame_sr[FRAME_SLOTS-2];
                                frame_sr <= frame_sr << 1;
                            end
                        end else if (slot_cnt == LAST_SLOT) begin
                            state <= S_HOLD;
                        end else begin
                            clk_spi_o <= 1'b1;
                            slot_cnt  <= slot_cnt + 1'b1;
                            if (is_read && slot_cnt >= SAMPLE_LO && slot_cnt <= SAMPLE_HI) begin
                                rd_shift <= {rd_shift[DATA_WIDTH-2:0], miso_i};
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!div_tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        cs_n_o  <= 1'b1;
                        mosi_o  <= 1'b0;
                        if (GAP_PULSES == 0) begin
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            if (is_read) begin
                                rdata_o <= rd_shift;
                            end
                        end else begin
                            state     <= S_GAP;
                            clk_spi_o <= 1'b1;
                            slot_cnt  <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (!div_tick) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (clk_spi_o) begin
                            clk_spi_o <= 1'b0;
                        end else if (slot_cnt == GAP_LAST) begin
                            state  <= S_IDLE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            if (is_read) begin
                                rdata_o <= rd_shift;
                            end
                        end else begin
                            clk_spi_o <= 1'b1;
                            slot_cnt  <= slot_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_spi_master.sv
// Self-checking bench for snn_spi_master: decodes SCLK/MOSI per slot, models the
// SPI slave on MISO, and compares frames, timing and read data against a reference.
module tb_snn_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default CLK_DIV=2
    logic        a_rst = 1'b1, a_req = 1'b0, a_we = 1'b0, a_miso = 1'b0;
    logic [8:0]  a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic        a_busy, a_done, a_sclk, a_cs_n, a_mosi;
    logic [31:0] a_rdata;

    // DUT B: CLK_DIV=1
    logic        b_rst = 1'b1, b_req = 1'b0, b_we = 1'b0, b_miso = 1'b0;
    logic [8:0]  b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic        b_busy, b_done, b_sclk, b_cs_n, b_mosi;
    logic [31:0] b_rdata;

    snn_spi_master dut_a (
        .clk_snn(clk), .rst_i(a_rst), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
        .wdata_i(a_wdata), .busy_o(a_busy), .done_o(a_done), .rdata_o(a_rdata),
        .clk_spi_o(a_sclk), .cs_n_o(a_cs_n), .mosi_o(a_mosi), .miso_i(a_miso)
    );

    snn_spi_master #(.CLK_DIV(1)) dut_b (
        .clk_snn(clk), .rst_i(b_rst), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
        .wdata_i(b_wdata), .busy_o(b_busy), .done_o(b_done), .rdata_o(b_rdata),
        .clk_spi_o(b_sclk), .cs_n_o(b_cs_n), .mosi_o(b_mosi), .miso_i(b_miso)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_rdata = '0;

    // Monitor state: frame bits at rising SCLK edges, edge counts, MOSI timing violations
    logic [56:0] a_frame = '0, b_frame = '0;
    int a_rises_low = 0, a_rises_high = 0, a_viol = 0, a_done_cnt = 0, a_rise_cnt = 0, a_stable = 0;
    int b_rises_low = 0, b_rises_high = 0, b_viol = 0, b_done_cnt = 0, b_stable = 0;
    logic a_sclk_prev = 1'b0, a_mosi_prev = 1'b0, b_sclk_prev = 1'b0, b_mosi_prev = 1'b0;
    logic [31:0] a_slave_word = '0;

    always @(negedge clk) begin
        if (!a_cs_n) begin
            if (!a_sclk_prev && a_sclk) begin
                a_frame = {a_frame[55:0], a_mosi};
                a_rises_low++;
                a_rise_cnt++;
                if (a_stable < 2) a_viol++;
            end
            if (a_sclk_prev && !a_sclk)
                a_miso = (a_rise_cnt >= 24 && a_rise_cnt <= 55) ? a_slave_word[55 - a_rise_cnt] : 1'b0;
            if (a_mosi !== a_mosi_prev && !(a_sclk_prev && !a_sclk)) a_viol++;
        end else begin
            if (!a_sclk_prev && a_sclk) a_rises_high++;
            a_rise_cnt = 0;
        end
        if (a_mosi !== a_mosi_prev) a_stable = 1; else a_stable++;
        a_sclk_prev = a_sclk;
        a_mosi_prev = a_mosi;
        if (a_done) a_done_cnt++;

        if (!b_cs_n) begin
            if (!b_sclk_prev && b_sclk) begin
                b_frame = {b_frame[55:0], b_mosi};
                b_rises_low++;
                if (b_stable < 1) b_viol++;
            end
            if (b_mosi !== b_mosi_prev && !(b_sclk_prev && !b_sclk)) b_viol++;
        end else if (!b_sclk_prev && b_sclk) begin
            b_rises_high++;
        end
        if (b_mosi !== b_mosi_prev) b_stable = 1; else b_stable++;
        b_sclk_prev = b_sclk;
        b_mosi_prev = b_mosi;
        if (b_done) b_done_cnt++;
    end

    // Reference frame: lead 0, instruction, zero-extended address, data (0 on reads), trailing 0
    function automatic logic [56:0] exp_frame(input logic we, input logic [8:0] addr, input logic [31:0] data);
        logic [6:0]  instr;
        logic [31:0] d;
        instr = we ? 7'b0000010 : 7'b0000011;
        d     = we ? data : 32'h0;
        return {1'b0, instr, {7'b0, addr}, d, 1'b0};
    endfunction

    task automatic run_frame_a(input logic we, input logic [8:0] addr, input logic [31:0] data,
                               input logic [31:0] slave, input int pulse_at,
                               output int cycles, output logic busy1, output logic csn1,
                               output logic [31:0] rdata_done, output logic busy_done);
        a_rises_low = 0; a_rises_high = 0; a_viol = 0; a_done_cnt = 0; a_frame = '0;
        a_slave_word = slave;
        @(negedge clk);
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
        @(negedge clk);
        a_req = 1'b0;
        busy1 = a_busy;
        csn1  = a_cs_n;
        cycles = 0;
        while (a_done !== 1'b1 && cycles < 1000) begin
            @(negedge clk);
            cycles++;
            if (cycles == pulse_at) begin
                a_req = 1'b1; a_we = ~we; a_addr = ~addr; a_wdata = ~data;
            end else begin
                a_req = 1'b0;
            end
        end
        rdata_done = a_rdata;
        busy_done  = a_busy;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_total++; if (a_cs_n !== 1'b1) $display("[TB] FAIL reset_cs_n: got %b expected 1", a_cs_n); else n_pass++;
        n_total++; if (a_sclk !== 1'b0) $display("[TB] FAIL reset_sclk: got %b expected 0", a_sclk); else n_pass++;
        n_total++; if ({a_busy, a_done, a_mosi} !== 3'b000) $display("[TB] FAIL reset_busy_done_mosi: got %b expected 000", {a_busy, a_done, a_mosi}); else n_pass++;
        n_total++; if (a_rdata !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected 00000000", a_rdata); else n_pass++;
        n_total++; if ({b_cs_n, b_sclk, b_busy, b_done} !== 4'b1000) $display("[TB] FAIL reset_b: got %b expected 1000", {b_cs_n, b_sclk, b_busy, b_done}); else n_pass++;
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int cyc; logic b1, c1, bd; logic [31:0] rd;
        run_frame_a(1'b1, 9'd5, 32'hDEADBEEF, 32'h0, -1, cyc, b1, c1, rd, bd);
        n_total++; if ({b1, c1} !== 2'b10) $display("[TB] FAIL write_start_busy_cs: got %b expected 10", {b1, c1}); else n_pass++;
        n_total++; if (cyc !== 240) $display("[TB] FAIL write_length: got %0d expected 240", cyc); else n_pass++;
        n_total++; if (bd !== 1'b0) $display("[TB] FAIL write_busy_at_done: got %b expected 0", bd); else n_pass++;
        n_total++; if (a_frame[55:49] !== 7'b0000010) $display("[TB] FAIL write_instr: got %b expected 0000010", a_frame[55:49]); else n_pass++;
        n_total++; if (a_frame[48:33] !== 16'h0005) $display("[TB] FAIL write_addr: got %h expected 0005", a_frame[48:33]); else n_pass++;
        n_total++; if (a_frame[32:1] !== 32'hDEADBEEF) $display("[TB] FAIL write_data: got %h expected deadbeef", a_frame[32:1]); else n_pass++;
        n_total++; if ({a_frame[56], a_frame[0]} !== 2'b00) $display("[TB] FAIL write_lead_trail: got %b expected 00", {a_frame[56], a_frame[0]}); else n_pass++;
        n_total++; if (a_rises_low !== 57) $display("[TB] FAIL write_rises_cs_low: got %0d expected 57", a_rises_low); else n_pass++;
        n_total++; if (a_rises_high !== 2) $display("[TB] FAIL write_rises_cs_high: got %0d expected 2", a_rises_high); else n_pass++;
        n_total++; if (a_viol !== 0) $display("[TB] FAIL write_mosi_timing: got %0d violations expected 0", a_viol); else n_pass++;
        n_total++; if (a_done_cnt !== 1) $display("[TB] FAIL write_done_count: got %0d expected 1", a_done_cnt); else n_pass++;
        n_total++; if (rd !== exp_rdata) $display("[TB] FAIL write_rdata_unchanged: got %h expected %h", rd, exp_rdata); else n_pass++;
    endtask

    task automatic test_read();
        int cyc; logic b1, c1, bd; logic [31:0] rd;
        run_frame_a(1'b0, 9'd384, 32'h12345678, 32'hA5A50F0F, -1, cyc, b1, c1, rd, bd);
        exp_rdata = 32'hA5A50F0F;
        n_total++; if (a_frame[55:49] !== 7'b0000011) $display("[TB] FAIL read_instr: got %b expected 0000011", a_frame[55:49]); else n_pass++;
        n_total++; if (a_frame !== exp_frame(1'b0, 9'd384, 32'h0)) $display("[TB] FAIL read_frame: got %h expected %h", a_frame, exp_frame(1'b0, 9'd384, 32'h0)); else n_pass++;
        n_total++; if (cyc !== 240) $display("[TB] FAIL read_length: got %0d expected 240", cyc); else n_pass++;
        n_total++; if (rd !== exp_rdata) $display("[TB] FAIL read_rdata: got %h expected %h", rd, exp_rdata); else n_pass++;
        run_frame_a(1'b1, 9'd17, 32'h0BADF00D, 32'hFFFFFFFF, -1, cyc, b1, c1, rd, bd);
        n_total++; if (rd !== exp_rdata) $display("[TB] FAIL read_persist_after_write: got %h expected %h", rd, exp_rdata); else n_pass++;
    endtask

    task automatic test_ignored_req();
        int cyc; logic b1, c1, bd; logic [31:0] rd;
        run_frame_a(1'b1, 9'h1A3, 32'hCAFEF00D, 32'h0, 9, cyc, b1, c1, rd, bd);
        repeat (5) @(negedge clk);
        n_total++; if (a_done_cnt !== 1) $display("[TB] FAIL ignored_req_done_count: got %0d expected 1", a_done_cnt); else n_pass++;
        n_total++; if (a_busy !== 1'b0) $display("[TB] FAIL ignored_req_no_restart: got busy %b expected 0", a_busy); else n_pass++;
        n_total++; if (a_frame !== exp_frame(1'b1, 9'h1A3, 32'hCAFEF00D)) $display("[TB] FAIL ignored_req_frame: got %h expected %h", a_frame, exp_frame(1'b1, 9'h1A3, 32'hCAFEF00D)); else n_pass++;
        n_total++; if (cyc !== 240) $display("[TB] FAIL ignored_req_length: got %0d expected 240", cyc); else n_pass++;
    endtask

    task automatic test_const_miso();
        int cyc; logic b1, c1, bd; logic [31:0] rd;
        run_frame_a(1'b0, 9'd3, 32'h0, 32'hFFFFFFFF, -1, cyc, b1, c1, rd, bd);
        n_total++; if (rd !== 32'hFFFFFFFF) $display("[TB] FAIL miso_const_one: got %h expected ffffffff", rd); else n_pass++;
        run_frame_a(1'b0, 9'd3, 32'h0, 32'h00000000, -1, cyc, b1, c1, rd, bd);
        exp_rdata = 32'h0;
        n_total++; if (rd !== 32'h00000000) $display("[TB] FAIL miso_const_zero: got %h expected 00000000", rd); else n_pass++;
    endtask

    task automatic test_random();
        int cyc; logic b1, c1, bd; logic [31:0] rd;
        logic we; logic [8:0] addr; logic [31:0] data, slave;
        for (int i = 0; i < 5; i++) begin
            we    = 1'($urandom_range(0, 1));
            addr  = 9'($urandom);
            data  = $urandom;
            slave = $urandom;
            run_frame_a(we, addr, data, slave, -1, cyc, b1, c1, rd, bd);
            if (!we) exp_rdata = slave;
            n_total++; if (a_frame !== exp_frame(we, addr, data)) $display("[TB] FAIL random_frame_%0d: got %h expected %h", i, a_frame, exp_frame(we, addr, data)); else n_pass++;
            n_total++; if (rd !== exp_rdata) $display("[TB] FAIL random_rdata_%0d: got %h expected %h", i, rd, exp_rdata); else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        int cyc; logic b1, c1, bd; logic [31:0] rd;
        a_done_cnt = 0;
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 9'h055; a_wdata = 32'h13579BDF;
        @(negedge clk);
        a_req = 1'b0;
        for (int i = 1; i < 100; i++) @(negedge clk);
        a_rst = 1'b1;
        @(negedge clk);
        exp_rdata = 32'h0;
        n_total++; if ({a_cs_n, a_sclk, a_busy, a_mosi, a_done} !== 5'b10000) $display("[TB] FAIL midreset_outputs: got %b expected 10000", {a_cs_n, a_sclk, a_busy, a_mosi, a_done}); else n_pass++;
        a_rst = 1'b0;
        repeat (300) @(negedge clk);
        n_total++; if (a_done_cnt !== 0) $display("[TB] FAIL midreset_no_done: got %0d expected 0", a_done_cnt); else n_pass++;
        run_frame_a(1'b1, 9'h0AA, 32'h2468ACE0, 32'h0, -1, cyc, b1, c1, rd, bd);
        n_total++; if (a_frame !== exp_frame(1'b1, 9'h0AA, 32'h2468ACE0)) $display("[TB] FAIL midreset_clean_frame: got %h expected %h", a_frame, exp_frame(1'b1, 9'h0AA, 32'h2468ACE0)); else n_pass++;
        n_total++; if (cyc !== 240 || a_rises_low !== 57 || a_rises_high !== 2) $display("[TB] FAIL midreset_clean_timing: got len %0d rises %0d/%0d expected 240 57/2", cyc, a_rises_low, a_rises_high); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int k;
        b_rises_low = 0; b_rises_high = 0; b_viol = 0; b_done_cnt = 0;
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 9'h101; b_wdata = 32'h89ABCDEF;
        @(negedge clk);
        n_total++; if ({b_busy, b_cs_n} !== 2'b10) $display("[TB] FAIL b2b_first_start: got %b expected 10", {b_busy, b_cs_n}); else n_pass++;
        k = 0;
        while (b_done !== 1'b1 && k < 500) begin @(negedge clk); k++; end
        n_total++; if (k !== 120) $display("[TB] FAIL b2b_first_length: got %0d expected 120", k); else n_pass++;
        n_total++; if (b_frame !== exp_frame(1'b1, 9'h101, 32'h89ABCDEF)) $display("[TB] FAIL b2b_first_frame: got %h expected %h", b_frame, exp_frame(1'b1, 9'h101, 32'h89ABCDEF)); else n_pass++;
        n_total++; if (b_rises_low !== 57 || b_rises_high !== 2) $display("[TB] FAIL b2b_first_rises: got %0d/%0d expected 57/2", b_rises_low, b_rises_high); else n_pass++;
        b_rises_low = 0; b_rises_high = 0;
        b_addr = 9'h0F0; b_wdata = 32'h55AA33CC;
        @(negedge clk);
        b_req = 1'b0;
        n_total++; if ({b_busy, b_cs_n} !== 2'b10) $display("[TB] FAIL b2b_second_start: got %b expected 10", {b_busy, b_cs_n}); else n_pass++;
        k = 0;
        while (b_done !== 1'b1 && k < 500) begin @(negedge clk); k++; end
        n_total++; if (k !== 120) $display("[TB] FAIL b2b_second_length: got %0d expected 120", k); else n_pass++;
        repeat (4) @(negedge clk);
        n_total++; if (b_frame !== exp_frame(1'b1, 9'h0F0, 32'h55AA33CC)) $display("[TB] FAIL b2b_second_frame: got %h expected %h", b_frame, exp_frame(1'b1, 9'h0F0, 32'h55AA33CC)); else n_pass++;
        n_total++; if (b_done_cnt !== 2 || b_viol !== 0) $display("[TB] FAIL b2b_done_and_timing: got done %0d viol %0d expected 2 0", b_done_cnt, b_viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignored_req();
        test_const_miso();
        test_random();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/snn_spi_master.md
# snn_spi_master

Single-clock SPI master that issues instruction/address/data frames to the SNN core's SPI slave port from a simple host request interface. It sits in the test/host-side logic and serialises one write or read per request in SPI mode 0, clocking out a full frame. On reads it captures 32 bits from MISO. After each frame it emits flush pulses with chip-select deasserted so the slave returns to idle.

## Interface
- INSTR_TRANS_WIDTH, 7: instruction slots per frame
- ADDR_TRANS_WIDTH, 16: address slots per frame; address zero-extended into this field
- DATA_WIDTH, 32: data bits per frame
- ADDR_WIDTH, 9: host address width
- INSTR_WRITE, 7'b0000010: instruction sent when we_i=1
- INSTR_READ, 7'b0000011: instruction sent when we_i=0
- CLK_DIV, 2: clk_snn cycles per SCLK half-period (≥1)
- GAP_PULSES, 2: SCLK periods generated with cs_n_o high after each frame

Ports:
- clk_snn in 1: system clock, all logic on rising edge
- rst_i in 1: reset, synchronous, active-high
- req_i in 1: start request; sampled only when idle
- we_i in 1: 1 = write frame, 0 = read frame
- addr_i in ADDR_WIDTH: target address
- wdata_i in DATA_WIDTH: write data
- busy_o out 1: frame in progress
- done_o out 1: one-cycle completion pulse
- rdata_o out DATA_WIDTH: last read result
- clk_spi_o out 1: SCLK, idle low
- cs_n_o out 1: chip select, active low
- mosi_o out 1: serial data to slave
- miso_i in 1: serial data from slave

## Operation
- Frame = 1 lead slot + INSTR_TRANS_WIDTH + ADDR_TRANS_WIDTH + DATA_WIDTH + 1 trailing slot = 57 slots at defaults.
  - Slot 0: lead, MOSI=0.
  - Slots 1–7: instruction, MSB first.
  - Slots 8–23: address zero-extended to 16 bits, MSB first.
  - Slots 24–55: data, MSB first. On reads these slots carry 0.
  - Slot 56: trailing, MOSI=0.
- States and transitions:
  - IDLE → SETUP when req_i=1. Latch we_i, addr_i and wdata_i into a frame shift register. Clear the slot and half-period counters.
  - SETUP: cs_n_o=0, clk_spi_o=0, mosi_o = slot 0, for CLK_DIV cycles; then go to SHIFT.
  - SHIFT: for each slot, hold clk_spi_o high for CLK_DIV cycles (rising edge), then low for CLK_DIV cycles (falling edge).
    - mosi_o changes only in the same cycle as a falling edge, taking the next slot's bit.
    - On reads, miso_i is shifted into the read register in the cycle clk_spi_o goes high, for slots 24–55 only.
    - After the falling edge of slot 56, go to HOLD.
  - HOLD: cs_n_o=0, SCLK low, for CLK_DIV cycles; then go to GAP.
  - GAP: cs_n_o=1, mosi_o=0, GAP_PULSES full SCLK periods (high CLK_DIV, low CLK_DIV); then go to IDLE.
  - On entry to IDLE: done_o=1 for one cycle; on reads rdata_o ← read register.
- req_i while busy is ignored; no queuing.
- rdata_o holds its value until the next read completes. Writes never change it.
- miso_i is sampled as-is, with no synchronizer; the slave is clocked by clk_spi_o.

## Timing
- Reset values: cs_n_o=1, clk_spi_o=0, mosi_o=0, busy_o=0, done_o=0, rdata_o=0, state IDLE.
- All outputs are registered.
- Request accepted at edge T: busy_o=1 and cs_n_o=0 from T+1.
- Frame length = CLK_DIV + 57·2·CLK_DIV + CLK_DIV + GAP_PULSES·2·CLK_DIV cycles.
  - Defaults: 2 + 228 + 2 + 8 = 240.
  - done_o=1 and busy_o=0 in cycle T+241.
- req_i asserted during the done_o cycle is accepted: back-to-back frames, no extra bubble.
- Exactly 57 rising SCLK edges per frame with cs_n_o low, plus GAP_PULSES rising edges with cs_n_o high.
- MOSI is stable for ≥CLK_DIV cycles before and after each rising edge.
- rst_i mid-frame: on the next edge, all outputs return to reset values. No done_o pulse; the frame is abandoned.
- CLK_DIV=1: SCLK = clk_snn/2. All rules above hold.

## Test plan
- Write, addr 5, data 0xDEADBEEF:
  - Decoded MOSI at rising edges: slots 1–7 = 0000010, 8–23 = 0x0005, 24–55 = 0xDEADBEEF.
  - 57 edges with cs_n_o low, then 2 edges with cs_n_o high.
  - done_o at T+241. rdata_o unchanged (0).
- Read, addr 384; slave model drives 0xA5A50F0F MSB first on slots 24–55:
  - Instruction field = 0000011.
  - rdata_o = 0xA5A50F0F in the done_o cycle, and it persists through a following write.
- req_i pulsed at T+10 during a frame → ignored: exactly one done_o, and frame contents unchanged.
- rst_i at T+100 of a write → next cycle cs_n_o=1, clk_spi_o=0, busy_o=0; no done_o. A new request afterwards produces a clean full frame.
- CLK_DIV=1, two requests back-to-back (second req_i held high through the first done_o):
  - Second frame starts at done cycle + 1.
  - Each frame lasts 1 + 114 + 1 + 4 = 120 cycles.
- Read with slave driving constant 1 → rdata_o = 0xFFFFFFFF. Driving constant 0 → rdata_o = 0x00000000.
